// File: rtl/axis_sync_fifo_pkt.sv
// -----------------------------------------------------------------------------
// axis_sync_fifo_pkt
//
// Single-clock AXI-Stream FIFO with first-word fall-through output and an
// optional store-and-forward packet mode.
//
// In word mode the output is valid whenever any word is stored. In packet
// mode a word is only offered once the packet it belongs to is complete
// (its tlast word is stored). A packet larger than the FIFO would never
// complete, so when the FIFO fills with no complete packet inside it,
// a release flag opens the output and the oversize packet cuts through
// until its tlast word leaves (or the FIFO runs dry).
//
// Ports
//   clk            : single clock, rising edge
//   rst_n          : asynchronous active-low reset
//   s_axis_tvalid  : upstream word valid
//   s_axis_tready  : FIFO can accept a word (low during and just after reset)
//   s_axis_tdata   : upstream data, P_DATA_WIDTH bits
//   s_axis_tlast   : last word of a packet
//   m_axis_tvalid  : output word valid
//   m_axis_tready  : downstream accepts the word
//   m_axis_tdata   : output data (fall-through from storage)
//   m_axis_tlast   : tlast stored with the output word
//   fill_level     : number of stored words
//   almost_full    : fill_level >= P_AFULL_THR
//   almost_empty   : fill_level <= P_AEMPTY_THR
//   pkt_count      : number of complete packets stored
// -----------------------------------------------------------------------------
module axis_sync_fifo_pkt #(
  parameter int P_DATA_WIDTH  = 16,
  parameter int P_FIFO_DEPTH  = 16,
  parameter int P_PACKET_MODE = 0,
  parameter int P_AFULL_THR   = P_FIFO_DEPTH - 2,
  parameter int P_AEMPTY_THR  = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,

  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  input  logic [P_DATA_WIDTH-1:0]         s_axis_tdata,
  input  logic                            s_axis_tlast,

  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic [P_DATA_WIDTH-1:0]         m_axis_tdata,
  output logic                            m_axis_tlast,

  output logic [$clog2(P_FIFO_DEPTH):0]   fill_level,
  output logic                            almost_full,
  output logic                            almost_empty,
  output logic [$clog2(P_FIFO_DEPTH):0]   pkt_count
);

  localparam int AW = $clog2(P_FIFO_DEPTH);  // pointer width
  localparam int CW = AW + 1;                // counter width (holds DEPTH)
  localparam int EW = P_DATA_WIDTH + 1;      // stored entry: {tlast, tdata}

  localparam logic [CW-1:0] C_DEPTH  = CW'(P_FIFO_DEPTH);
  localparam logic [CW-1:0] C_AFULL  = CW'(P_AFULL_THR);
  localparam logic [CW-1:0] C_AEMPTY = CW'(P_AEMPTY_THR);
  localparam logic [CW-1:0] C_ONE    = CW'(1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [EW-1:0] r_mem [P_FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_fill_level;
  logic [CW-1:0] r_pkt_count;
  logic          r_release;
  // Holds tready low through reset and releases it on the first edge after
  // rst_n rises, so upstream never sees the FIFO ready while it is clearing.
  logic          r_ready_en;

  // ---------------------------------------------------------------------------
  // Handshake decode
  // ---------------------------------------------------------------------------
  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic          w_push_last;
  logic          w_pop_last;
  logic [EW-1:0] w_rd_word;

  assign w_full  = (r_fill_level == C_DEPTH);
  assign w_empty = (r_fill_level == '0);

  // tready comes only from registers, so it never depends on s_axis_tvalid.
  assign s_axis_tready = r_ready_en && !w_full;

  generate
    if (P_PACKET_MODE != 0) begin : g_pkt_valid
      assign m_axis_tvalid = !w_empty && ((r_pkt_count != '0) || r_release);
    end else begin : g_word_valid
      assign m_axis_tvalid = !w_empty;
    end
  endgenerate

  assign w_push      = s_axis_tvalid && s_axis_tready;
  assign w_pop       = m_axis_tvalid && m_axis_tready;
  assign w_push_last = w_push && s_axis_tlast;
  assign w_pop_last  = w_pop && m_axis_tlast;

  // Fall-through read: the head entry is always on the output. While stalled
  // neither r_rd_ptr nor the head entry can change (writes only target free
  // slots), so data/tlast stay stable as the stream protocol requires.
  assign w_rd_word    = r_mem[r_rd_ptr];
  assign m_axis_tdata = w_rd_word[P_DATA_WIDTH-1:0];
  assign m_axis_tlast = w_rd_word[P_DATA_WIDTH];

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  logic [CW-1:0] w_fill_nxt;
  logic [CW-1:0] w_pkt_nxt;
  logic          w_release_nxt;

  // NOTE: every output of a combinational block gets a default on entry;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    w_fill_nxt = r_fill_level;
    unique case ({w_push, w_pop})
      2'b10:   w_fill_nxt = r_fill_level + C_ONE;
      2'b01:   w_fill_nxt = r_fill_level - C_ONE;
      default: w_fill_nxt = r_fill_level;
    endcase

    w_pkt_nxt = r_pkt_count;
    unique case ({w_push_last, w_pop_last})
      2'b10:   w_pkt_nxt = r_pkt_count + C_ONE;
      2'b01:   w_pkt_nxt = r_pkt_count - C_ONE;
      default: w_pkt_nxt = r_pkt_count;
    endcase

    // Release opens the output for a packet that cannot fit: FIFO full and
    // not one complete packet inside. It closes once that packet's tlast
    // leaves, or when the FIFO drains mid-packet (the remainder then waits
    // for its tlast like any other packet).
    w_release_nxt = r_release;
    if (w_pop_last || (w_fill_nxt == '0)) begin
      w_release_nxt = 1'b0;
    end else if (w_full && (r_pkt_count == '0)) begin
      w_release_nxt = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_fill_level <= '0;
      r_pkt_count  <= '0;
      r_release    <= 1'b0;
      r_ready_en   <= 1'b0;
    end else begin
      r_ready_en   <= 1'b1;
      r_fill_level <= w_fill_nxt;
      r_pkt_count  <= w_pkt_nxt;
      r_release    <= w_release_nxt;
      // Depth is a power of two, so the natural roll-over of an AW-bit
      // pointer is the wrap from DEPTH-1 back to 0.
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  // NOTE: the memory has no reset; clearing the pointers and fill level is
  // what discards old words, and stale contents are never presented as valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {s_axis_tlast, s_axis_tdata};
    end
  end

  // ---------------------------------------------------------------------------
  // Status outputs (decoded from registers only, so glitch-free per cycle)
  // ---------------------------------------------------------------------------
  assign fill_level   = r_fill_level;
  assign pkt_count    = r_pkt_count;
  assign almost_full  = (r_fill_level >= C_AFULL);
  assign almost_empty = (r_fill_level <= C_AEMPTY);

endmodule

// File: tb/tb_axis_sync_fifo_pkt.sv
// -----------------------------------------------------------------------------
// tb_axis_sync_fifo_pkt
//
// Drives a word-mode and a packet-mode instance (depth 8, 16-bit data) with
// the same stimulus; `mode` picks which instance's outputs are checked.
// Inputs change 1 time unit after the rising edge, outputs are sampled on
// the falling edge. Every accepted input word is pushed to a queue and
// every accepted output word is compared against the queue head.
// -----------------------------------------------------------------------------
module tb_axis_sync_fifo_pkt;

  localparam int DW = 16;
  localparam int DEPTH = 8;
  localparam int CW = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          s_tvalid = 1'b0;
  logic [DW-1:0] s_tdata = '0;
  logic          s_tlast = 1'b0;
  logic          m_tready = 1'b0;

  // word-mode instance outputs
  logic          w_s_tready, w_m_tvalid, w_m_tlast, w_afull, w_aempty;
  logic [DW-1:0] w_m_tdata;
  logic [CW-1:0] w_fill, w_pkt;
  // packet-mode instance outputs
  logic          p_s_tready, p_m_tvalid, p_m_tlast, p_afull, p_aempty;
  logic [DW-1:0] p_m_tdata;
  logic [CW-1:0] p_fill, p_pkt;

  logic          mode = 1'b0;  // 0 = check word-mode DUT, 1 = packet-mode DUT
  logic          s_tready_sel, m_tvalid_sel, m_tlast_sel, afull_sel, aempty_sel;
  logic [DW-1:0] m_tdata_sel;
  logic [CW-1:0] fill_sel, pkt_sel;

  assign s_tready_sel = mode ? p_s_tready : w_s_tready;
  assign m_tvalid_sel = mode ? p_m_tvalid : w_m_tvalid;
  assign m_tlast_sel  = mode ? p_m_tlast  : w_m_tlast;
  assign m_tdata_sel  = mode ? p_m_tdata  : w_m_tdata;
  assign afull_sel    = mode ? p_afull    : w_afull;
  assign aempty_sel   = mode ? p_aempty   : w_aempty;
  assign fill_sel     = mode ? p_fill     : w_fill;
  assign pkt_sel      = mode ? p_pkt      : w_pkt;

  axis_sync_fifo_pkt #(
    .P_DATA_WIDTH (DW),
    .P_FIFO_DEPTH (DEPTH),
    .P_PACKET_MODE(0)
  ) u_dut_word (
    .clk          (clk),
    .rst_n        (rst_n),
    .s_axis_tvalid(s_tvalid),
    .s_axis_tready(w_s_tready),
    .s_axis_tdata (s_tdata),
    .s_axis_tlast (s_tlast),
    .m_axis_tvalid(w_m_tvalid),
    .m_axis_tready(m_tready),
    .m_axis_tdata (w_m_tdata),
    .m_axis_tlast (w_m_tlast),
    .fill_level   (w_fill),
    .almost_full  (w_afull),
    .almost_empty (w_aempty),
    .pkt_count    (w_pkt)
  );

  axis_sync_fifo_pkt #(
    .P_DATA_WIDTH (DW),
    .P_FIFO_DEPTH (DEPTH),
    .P_PACKET_MODE(1)
  ) u_dut_pkt (
    .clk          (clk),
    .rst_n        (rst_n),
    .s_axis_tvalid(s_tvalid),
    .s_axis_tready(p_s_tready),
    .s_axis_tdata (s_tdata),
    .s_axis_tlast (s_tlast),
    .m_axis_tvalid(p_m_tvalid),
    .m_axis_tready(m_tready),
    .m_axis_tdata (p_m_tdata),
    .m_axis_tlast (p_m_tlast),
    .fill_level   (p_fill),
    .almost_full  (p_afull),
    .almost_empty (p_aempty),
    .pkt_count    (p_pkt)
  );

  initial forever #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Downstream ready: 0 = held low, 1 = held high, 2 = random 50%
  // ---------------------------------------------------------------------------
  int rdy_mode = 0;

  task automatic set_rdy(input int m);
    rdy_mode = m;
    if (m == 0) m_tready = 1'b0;
    if (m == 1) m_tready = 1'b1;
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      0:       m_tready = 1'b0;
      1:       m_tready = 1'b1;
      default: m_tready = ($urandom_range(0, 1) == 1);
    endcase
  end

  // ---------------------------------------------------------------------------
  // Scoreboard monitor (falling edge)
  // ---------------------------------------------------------------------------
  logic [DW:0] q[$];
  logic        prev_stall = 1'b0;
  logic [DW:0] prev_word = '0;
  logic        saw_release = 1'b0;

  always @(negedge clk) begin
    logic [DW:0] exp_word;
    if (rst_n) begin
      if (prev_stall) begin
        check("stall_valid", 32'(m_tvalid_sel), 32'd1);
        check("stall_data", 32'({m_tlast_sel, m_tdata_sel}), 32'(prev_word));
      end
      if (m_tvalid_sel && m_tready) begin
        if (mode && (pkt_sel == '0)) saw_release = 1'b1;
        if (q.size() == 0) begin
          check("pop_unexpected_qsize", 32'(q.size()), 32'd1);
        end else begin
          exp_word = q.pop_front();
          check("pop_data", 32'({m_tlast_sel, m_tdata_sel}), 32'(exp_word));
        end
      end
      if (s_tvalid && s_tready_sel) q.push_back({s_tlast, s_tdata});
      prev_stall = m_tvalid_sel && !m_tready;
      prev_word  = {m_tlast_sel, m_tdata_sel};
    end else begin
      prev_stall = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic drive_word(input logic [DW-1:0] d, input logic l);
    bit ok = 1'b0;
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tlast  = l;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk);
      ok = s_tready_sel;  // handshake completes on the coming rising edge
      @(posedge clk);
      #1;
    end
    check("push_accept", 32'(ok), 32'd1);
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic wait_empty(input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      if (fill_sel == '0 && q.size() == 0) break;
      @(posedge clk);
      #1;
    end
    check("drain_fill", 32'(fill_sel), 32'd0);
    check("drain_q", 32'(q.size()), 32'd0);
  endtask

  task automatic do_reset();
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    rst_n    = 1'b0;
    q.delete();
    repeat (2) @(posedge clk);
    #1;
    check("rst_tready", 32'(s_tready_sel), 32'd0);
    check("rst_tvalid", 32'(m_tvalid_sel), 32'd0);
    check("rst_fill", 32'(fill_sel), 32'd0);
    check("rst_pkt", 32'(pkt_sel), 32'd0);
    check("rst_aempty", 32'(aempty_sel), 32'd1);
    check("rst_afull", 32'(afull_sel), 32'd0);
    rst_n = 1'b1;
    #1;
    check("rst_tready_pre_edge", 32'(s_tready_sel), 32'd0);
    @(posedge clk);
    #1;
    check("rst_tready_post_edge", 32'(s_tready_sel), 32'd1);
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    #1 rst_n = 1'b0;

    // Word-mode fill to full, then drain
    mode = 1'b0;
    set_rdy(0);
    do_reset();
    for (int i = 1; i <= DEPTH; i++) begin
      drive_word(DW'(i), 1'b0);
      check("fill_count", 32'(fill_sel), 32'(i));
      check("afull_thr", 32'(afull_sel), 32'(i >= DEPTH - 2));
      check("aempty_thr", 32'(aempty_sel), 32'(i <= 2));
    end
    check("full_tready", 32'(s_tready_sel), 32'd0);
    check("full_tvalid", 32'(m_tvalid_sel), 32'd1);
    set_rdy(1);
    wait_empty(40);
    check("drained_aempty", 32'(aempty_sel), 32'd1);

    // Simultaneous push/pop at fill_level 3 for 20 cycles
    set_rdy(0);
    for (int i = 0; i < 3; i++) drive_word(DW'(16'h0300 + i), 1'b0);
    set_rdy(1);
    for (int i = 0; i < 20; i++) begin
      drive_word(DW'(16'h0400 + i), 1'b0);
      check("steady_fill", 32'(fill_sel), 32'd3);
    end
    wait_empty(40);

    // Packet mode: three-word packet held until its tlast is stored
    mode = 1'b1;
    set_rdy(1);
    do_reset();
    drive_word(16'h00A0, 1'b0);
    check("pkt_hold0", 32'(m_tvalid_sel), 32'd0);
    drive_word(16'h00A1, 1'b0);
    check("pkt_hold1", 32'(m_tvalid_sel), 32'd0);
    drive_word(16'h00A2, 1'b1);
    check("pkt_ready", 32'(m_tvalid_sel), 32'd1);
    check("pkt_count1", 32'(pkt_sel), 32'd1);
    wait_empty(40);
    check("pkt_count0", 32'(pkt_sel), 32'd0);

    // Packet mode: oversize packet forces cut-through
    do_reset();
    saw_release = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive_word(DW'(16'h00B0 + i), (i == 9));
      if (i == DEPTH - 1) check("ovr_full", 32'(fill_sel), 32'(DEPTH));
    end
    wait_empty(60);
    check("ovr_release_seen", 32'(saw_release), 32'd1);
    check("ovr_pkt0", 32'(pkt_sel), 32'd0);

    // Random backpressure in word mode
    mode = 1'b0;
    do_reset();
    set_rdy(2);
    for (int i = 0; i < 40; i++) begin
      drive_word(DW'($urandom), ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    wait_empty(300);

    // Reset mid-operation at fill_level 5
    set_rdy(0);
    for (int i = 0; i < 5; i++) drive_word(DW'(16'h0700 + i), 1'b0);
    check("mid_fill", 32'(fill_sel), 32'd5);
    #1;
    rst_n = 1'b0;
    q.delete();
    #1;
    check("mid_rst_fill", 32'(fill_sel), 32'd0);
    check("mid_rst_tvalid", 32'(m_tvalid_sel), 32'd0);
    do_reset();
    set_rdy(1);
    drive_word(16'h5555, 1'b0);
    check("post_rst_tvalid", 32'(m_tvalid_sel), 32'd1);
    check("post_rst_data", 32'(m_tdata_sel), 32'h5555);
    wait_empty(20);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/axis_sync_fifo_pkt.md
AXIS_SYNC_FIFO_PKT -- requirements
Module: axis_sync_fifo_pkt

Interface
REQ-001 SHALL have parameter P_DATA_WIDTH, default 16, tdata width in bits (1..1024).
REQ-002 SHALL have parameter P_FIFO_DEPTH, default 16, entry count (power of 2, 4..4096).
REQ-003 SHALL have parameter P_PACKET_MODE, default 0, 0 = word mode, 1 = store-and-forward packet mode.
REQ-004 SHALL have parameter P_AFULL_THR, default P_FIFO_DEPTH-2, almost_full asserts when fill_level >= value.
REQ-005 SHALL have parameter P_AEMPTY_THR, default 2, almost_empty asserts when fill_level <= value.
REQ-006 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-007 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port s_axis_tvalid, input, 1, upstream word valid.
REQ-009 SHALL have port s_axis_tready, output, 1, FIFO can accept a word.
REQ-010 SHALL have port s_axis_tdata, input, P_DATA_WIDTH, upstream data.
REQ-011 SHALL have port s_axis_tlast, input, 1, last word of a packet.
REQ-012 SHALL have port m_axis_tvalid, output, 1, output word valid.
REQ-013 SHALL have port m_axis_tready, input, 1, downstream accepts the word.
REQ-014 SHALL have port m_axis_tdata, output, P_DATA_WIDTH, output data.
REQ-015 SHALL have port m_axis_tlast, output, 1, tlast stored with the word.
REQ-016 SHALL have port fill_level, output, $clog2(P_FIFO_DEPTH)+1, number of stored words.
REQ-017 SHALL have ports almost_full and almost_empty, output, 1, threshold flags.
REQ-018 SHALL have port pkt_count, output, $clog2(P_FIFO_DEPTH)+1, number of complete packets stored.

Function
REQ-019 SHALL push a word on cycles where s_axis_tvalid && s_axis_tready, storing {tlast, tdata} at wr_ptr.
REQ-020 SHALL pop a word on cycles where m_axis_tvalid && m_axis_tready, advancing rd_ptr.
REQ-021 SHALL wrap wr_ptr and rd_ptr from P_FIFO_DEPTH-1 to 0.
REQ-022 SHALL drive s_axis_tready = (fill_level != P_FIFO_DEPTH), decoded from registered state only.
REQ-023 SHALL make output first-word fall-through: m_axis_tdata and m_axis_tlast equal mem[rd_ptr] combinationally.
REQ-024 SHALL give a latency of 1 cycle: a word pushed at edge N is presentable with m_axis_tvalid high after edge N.
REQ-025 SHALL leave fill_level unchanged on a simultaneous push and pop, add 1 on push only, and subtract 1 on pop only.
REQ-026 SHALL not push when full, because tready is low then.
REQ-027 SHALL not pop when empty, because tvalid is low then.
REQ-028 SHALL, in word mode, drive m_axis_tvalid = (fill_level != 0).
REQ-029 SHALL maintain pkt_count: +1 on a push with tlast, -1 on a pop with tlast, unchanged when both occur in one cycle.
REQ-030 SHALL, in packet mode, drive m_axis_tvalid = (fill_level != 0) && (pkt_count != 0 || release).
REQ-031 SHALL set release when fill_level == P_FIFO_DEPTH && pkt_count == 0, forcing cut-through of an oversize packet.
REQ-032 SHALL clear release on the pop of a tlast word, or when fill_level reaches 0.
REQ-033 SHALL compute almost_full and almost_empty combinationally from fill_level, glitch-free relative to clk.
REQ-034 SHALL hold m_axis_tdata, m_axis_tlast and m_axis_tvalid stable while m_axis_tvalid && !m_axis_tready (AXI-Stream rule).

Reset
REQ-035 SHALL, on rst_n low, immediately clear wr_ptr, rd_ptr, fill_level, pkt_count and release without waiting for clk.
REQ-036 SHALL drive outputs during reset as: s_axis_tready=0, m_axis_tvalid=0, fill_level=0, pkt_count=0, almost_empty=1, almost_full=0.
REQ-037 SHALL not reset memory contents; m_axis_tdata is don't-care while m_axis_tvalid=0.
REQ-038 SHALL deassert reset synchronously at the integration level, and assert s_axis_tready on the first clk edge after rst_n rises.
REQ-039 SHALL discard all stored words on reset mid-operation; no word stored before reset is output after it.

Verification (P_DATA_WIDTH=16, P_FIFO_DEPTH=8)
REQ-040 SHALL cover word-mode fill: push 0x0001..0x0008 with m_axis_tready=0 -> fill_level=8, s_axis_tready=0, almost_full=1; then drain -> words out 0x0001..0x0008 in order, fill_level=0, almost_empty=1.
REQ-041 SHALL cover simultaneous push/pop: at fill_level=3, push and pop every cycle for 20 cycles -> fill_level stays 3, output order is preserved, and pointers wrap at least twice.
REQ-042 SHALL cover packet mode: push 0xA0,0xA1,0xA2 (tlast on 0xA2) one per cycle -> m_axis_tvalid=0 until the cycle after the 0xA2 push, then 3 words out with tlast on 0xA2 and pkt_count returns to 0.
REQ-043 SHALL cover oversize packet in packet mode: push 10 words with no tlast until the 10th -> at fill_level=8 release asserts, words stream out, and all 10 words are output with tlast on the 10th.
REQ-044 SHALL cover backpressure: stall m_axis_tready randomly at 50% -> m_axis_tdata and m_axis_tvalid are stable across every stalled cycle, with no loss or duplication.
REQ-045 SHALL cover reset mid-operation: assert rst_n=0 at fill_level=5 between clk edges -> fill_level=0 and m_axis_tvalid=0 immediately, and the next pushed word 0x5555 is the first word output.
